// File: rtl/counter_mod_updown.sv
// counter_mod_updown: modulo-N up/down counter with load clamp, tc pulse and sticky ovf.
// Define COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module counter_mod_updown #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             ovf_o
);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d, step_val, load_sat;
    logic             tc_q, tc_d, ovf_q, ovf_d;
    logic [WIDTH:0]   inc, dec;
    logic             at_top, at_bot, wrap;

    // One extra bit keeps MODULUS = 2^WIDTH comparable and exposes the borrow at 0.
    assign inc    = {1'b0, q_q} + 1'b1;
    assign dec    = {1'b0, q_q} - 1'b1;
    assign at_top = inc == MOD_W;
    assign at_bot = dec[WIDTH];

    always_comb begin
        wrap     = en_i && !load_i && (up_i ? at_top : at_bot);
        load_sat = ({1'b0, load_val_i} >= MOD_W) ? TOP : load_val_i;
`ifdef COUNTER_SAT_EN
        step_val = wrap ? q_q : (up_i ? inc[WIDTH-1:0] : dec[WIDTH-1:0]);
`else
        step_val = wrap ? (up_i ? '0 : TOP) : (up_i ? inc[WIDTH-1:0] : dec[WIDTH-1:0]);
`endif
        q_d   = load_i ? load_sat : (en_i ? step_val : q_q);
        tc_d  = wrap;
        ovf_d = wrap || (ovf_q && !ovf_clr_i);
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o   = q_q;
    assign tc_o  = tc_q;
    assign ovf_o = ovf_q;
endmodule

// File: doc/counter_mod_updown.md
# counter_mod_updown

Parametrised synchronous modulo-N up/down counter with parallel load, count enable, terminal-count pulse and sticky overflow flag. It generalises the fixed 3-bit ripple-style T-flip-flop counter to arbitrary width and modulus, adding a direction control. It is the standard counting primitive for timers, clock dividers and sequence generators in the lab designs.

## Interface
- WIDTH, 4: counter width in bits; at least 1.
- MODULUS, 10: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- clock  in  1  single clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- en  in  1  count enable; one step per enabled cycle.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value loaded when load = 1.
- ovf_clr  in  1  clears the sticky overflow flag.
- q  out  WIDTH  registered count value.
- tc  out  1  registered terminal-count pulse; one cycle per wrap event.
- ovf  out  1  registered sticky flag; set by any wrap event.

## Operation
- Priority on each rising edge: clear > load > en > hold.
- clear: q ← 0, tc ← 0, ovf ← 0, regardless of every other input.
- load: q ← load_val. If load_val ≥ MODULUS, q ← MODULUS-1 (clamp). No wrap event. tc ← 0. ovf is unchanged, apart from ovf_clr.
- en, up = 1: if q = MODULUS-1, q ← 0 and a wrap event occurs. Otherwise q ← q+1.
- en, up = 0: if q = 0, q ← MODULUS-1 and a wrap event occurs. Otherwise q ← q-1.
- en = 0, no load: q holds and tc ← 0.
- Wrap event: tc ← 1 for exactly that cycle. ovf ← 1.
- ovf_clr: ovf ← 0, unless a wrap event occurs on the same edge; the set wins.
- Arithmetic: compute the increment and decrement in WIDTH+1 bits so that MODULUS = 2^WIDTH wraps correctly with no truncation hazard. q never holds a value ≥ MODULUS.
- Direction may change on any cycle; the step uses the up value sampled on that edge.
- No state machine beyond the count register. tc and ovf are pure functions of the edge event.

## Timing
- Reset values: q = 0, tc = 0, ovf = 0. Reset takes effect one edge after clear is high.
- Latency: 1 cycle from en, load or ovf_clr to the updated q, tc or ovf.
- tc is high in the same cycle that q shows the wrapped value: 0 when counting up, MODULUS-1 when counting down.
- With en held high and up = 1, tc has period MODULUS cycles and is high for 1 cycle.
- clear asserted mid-count aborts the count; the next cycle shows q = 0 with no tc.
- load and en asserted together: the load wins and the count step is discarded.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- COUNTER_SAT_EN defined: the counter saturates instead of wrapping.
  - Up step at MODULUS-1 holds q at MODULUS-1.
  - Down step at 0 holds q at 0.
  - The attempted step past the boundary is still a wrap event: tc pulses and ovf sets.
  - Each further attempted step while saturated pulses tc again.
- COUNTER_SAT_EN undefined: modulo wrap as described in Operation.
- Load clamping and all other behaviour are identical in both builds.

## Test plan
- Setup for all scenarios: WIDTH = 4, MODULUS = 10.
- Reset: with q = 7 and ovf = 1, assert clear for 1 cycle with en = 1. Next cycle: q = 0, tc = 0, ovf = 0.
- Up wrap: from q = 0, hold en = 1, up = 1 for 12 cycles.
  - q runs 1..9, 0, 1, 2.
  - tc is high only in the cycle where q = 0.
  - ovf = 1 from then on.
- Down wrap and ovf_clr: load 1, then en = 1, up = 0.
  - q runs 0, 9, 8.
  - tc is high where q = 9.
  - ovf_clr on a non-wrap cycle clears ovf.
  - ovf_clr on the wrap cycle leaves ovf = 1.
- Load priority and clamp:
  - load = 1, en = 1, load_val = 5 gives q = 5 with no step.
  - load_val = 14 gives q = 9.
  - tc = 0 in both cases.
- Hold and direction flip:
  - en = 0 for 3 cycles holds q = 4.
  - Alternating up = 1/0 with en = 1 gives q = 5, 4, 5, 4.
- COUNTER_SAT_EN build: from q = 8, up = 1, en = 1 for 3 cycles.
  - q runs 9, 9, 9.
  - tc is high on the 2nd and 3rd cycles.
  - ovf = 1.
  - The down direction at q = 0 behaves symmetrically.
